// File: rtl/axi_stream_splitter_6.sv
// One-input, six-output AXI-stream splitter routed by an 8-bit dest field.
// Each output owns a one-entry holding register; unmatched beats are dropped and counted.
module axi_stream_splitter_6 #(
    parameter int unsigned INPUT_DATA_WIDTH  = 32,
    parameter int unsigned OUTPUT_DATA_WIDTH = 16,
    parameter string       MSB_DEST_SUPPORT  = "TRUE",
    parameter logic [7:0]  DEST_1            = 8'd0,
    parameter logic [7:0]  DEST_2            = 8'd1,
    parameter logic [7:0]  DEST_3            = 8'd2,
    parameter logic [7:0]  DEST_4            = 8'd3,
    parameter logic [7:0]  DEST_5            = 8'd4,
    parameter logic [7:0]  DEST_6            = 8'd5
) (
    input  logic                         clock,
    input  logic                         reset,

    input  logic [INPUT_DATA_WIDTH-1:0]  stream_in_data,
    input  logic [7:0]                   stream_in_dest,
    input  logic [7:0]                   stream_in_user,
    input  logic                         stream_in_last,
    input  logic                         stream_in_valid,
    output logic                         stream_in_ready,

    output logic [OUTPUT_DATA_WIDTH-1:0] stream_out_1_data,
    output logic [7:0]                   stream_out_1_dest,
    output logic [7:0]                   stream_out_1_user,
    output logic                         stream_out_1_last,
    output logic                         stream_out_1_valid,
    input  logic                         stream_out_1_ready,

    output logic [OUTPUT_DATA_WIDTH-1:0] stream_out_2_data,
    output logic [7:0]                   stream_out_2_dest,
    output logic [7:0]                   stream_out_2_user,
    output logic                         stream_out_2_last,
    output logic                         stream_out_2_valid,
    input  logic                         stream_out_2_ready,

    output logic [OUTPUT_DATA_WIDTH-1:0] stream_out_3_data,
    output logic [7:0]                   stream_out_3_dest,
    output logic [7:0]                   stream_out_3_user,
    output logic                         stream_out_3_last,
    output logic                         stream_out_3_valid,
    input  logic                         stream_out_3_ready,

    output logic [OUTPUT_DATA_WIDTH-1:0] stream_out_4_data,
    output logic [7:0]                   stream_out_4_dest,
    output logic [7:0]                   stream_out_4_user,
    output logic                         stream_out_4_last,
    output logic                         stream_out_4_valid,
    input  logic                         stream_out_4_ready,

    output logic [OUTPUT_DATA_WIDTH-1:0] stream_out_5_data,
    output logic [7:0]                   stream_out_5_dest,
    output logic [7:0]                   stream_out_5_user,
    output logic                         stream_out_5_last,
    output logic                         stream_out_5_valid,
    input  logic                         stream_out_5_ready,

    output logic [OUTPUT_DATA_WIDTH-1:0] stream_out_6_data,
    output logic [7:0]                   stream_out_6_dest,
    output logic [7:0]                   stream_out_6_user,
    output logic                         stream_out_6_last,
    output logic                         stream_out_6_valid,
    input  logic                         stream_out_6_ready,

    output logic [15:0]                  dropped_count
);

    localparam int unsigned NUM_OUT = 6;
    localparam int unsigned DEST_W  = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [NUM_OUT*DEST_W-1:0] DEST_TAB =
        {DEST_6, DEST_5, DEST_4, DEST_3, DEST_2, DEST_1};

    typedef struct packed {
        logic [OUTPUT_DATA_WIDTH-1:0] data;
        logic [DEST_W-1:0]            dest;
        logic [7:0]                   user;
        logic                         last;
    } beat_t;

    logic [DEST_W-1:0]  rdest;
    logic               hit;
    logic [IDX_W-1:0]   target;
    logic               xfer;
    logic [NUM_OUT-1:0] load;
    logic [NUM_OUT-1:0] out_ready;
    logic [NUM_OUT-1:0] valid_q;
    beat_t              beat_q [NUM_OUT];
    beat_t              in_beat;
    logic               unused_in;

    // Routing dest comes from the top byte of data or from the dest sideband.
    generate
        if (MSB_DEST_SUPPORT == "TRUE") begin : g_msb_dest
            assign rdest = stream_in_data[INPUT_DATA_WIDTH-1 -: DEST_W];
        end else begin : g_side_dest
            assign rdest = stream_in_dest;
        end
    endgenerate

    // Bits between the payload and the dest byte are deliberately ignored.
    assign unused_in = ^{stream_in_data, stream_in_dest};

    assign out_ready = {stream_out_6_ready, stream_out_5_ready, stream_out_4_ready,
                        stream_out_3_ready, stream_out_2_ready, stream_out_1_ready};

    // Lowest-index match wins, so scan downward and let later hits overwrite.
    always_comb begin
        hit    = 1'b0;
        target = '0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            if (rdest == DEST_TAB[k*DEST_W +: DEST_W]) begin
                hit    = 1'b1;
                target = IDX_W'(k);
            end
        end
    end

    assign stream_in_ready = reset & (hit ? (~valid_q[target] | out_ready[target]) : 1'b1);
    assign xfer            = stream_in_valid & stream_in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            load[k] = xfer & hit & (target == IDX_W'(k));
        end
    end

    assign in_beat.data = stream_in_data[OUTPUT_DATA_WIDTH-1:0];
    assign in_beat.dest = rdest;
    assign in_beat.user = stream_in_user;
    assign in_beat.last = stream_in_last;

    // Holding registers: a load wins over a drain so back-to-back beats never bubble.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                beat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (load[k]) begin
                    beat_q[k]  <= in_beat;
                    valid_q[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of beats consumed without a matching output.
    always_ff @(posedge clock) begin
        if (!reset) begin
            dropped_count <= '0;
        end else if (xfer && !hit && dropped_count != CNT_MAX) begin
            dropped_count <= dropped_count + CNT_W'(1);
        end
    end

    assign stream_out_1_data  = beat_q[0].data;
    assign stream_out_1_dest  = beat_q[0].dest;
    assign stream_out_1_user  = beat_q[0].user;
    assign stream_out_1_last  = beat_q[0].last;
    assign stream_out_1_valid = valid_q[0];

    assign stream_out_2_data  = beat_q[1].data;
    assign stream_out_2_dest  = beat_q[1].dest;
    assign stream_out_2_user  = beat_q[1].user;
    assign stream_out_2_last  = beat_q[1].last;
    assign stream_out_2_valid = valid_q[1];

    assign stream_out_3_data  = beat_q[2].data;
    assign stream_out_3_dest  = beat_q[2].dest;
    assign stream_out_3_user  = beat_q[2].user;
    assign stream_out_3_last  = beat_q[2].last;
    assign stream_out_3_valid = valid_q[2];

    assign stream_out_4_data  = beat_q[3].data;
    assign stream_out_4_dest  = beat_q[3].dest;
    assign stream_out_4_user  = beat_q[3].user;
    assign stream_out_4_last  = beat_q[3].last;
    assign stream_out_4_valid = valid_q[3];

    assign stream_out_5_data  = beat_q[4].data;
    assign stream_out_5_dest  = beat_q[4].dest;
    assign stream_out_5_user  = beat_q[4].user;
    assign stream_out_5_last  = beat_q[4].last;
    assign stream_out_5_valid = valid_q[4];

    assign stream_out_6_data  = beat_q[5].data;
    assign stream_out_6_dest  = beat_q[5].dest;
    assign stream_out_6_user  = beat_q[5].user;
    assign stream_out_6_last  = beat_q[5].last;
    assign stream_out_6_valid = valid_q[5];

endmodule

// File: tb/tb_axi_stream_splitter_6.sv
// Directed bench for axi_stream_splitter_6: a vector table for routing and
// backpressure, hand sequences for reset and sideband-dest mode.
module tb_axi_stream_splitter_6;

    logic        clock = 1'b0;
    logic        reset;

    logic [31:0] in_data;
    logic [7:0]  in_dest, in_user;
    logic        in_last, in_valid, in_ready;
    logic [15:0] o_data [6];
    logic [7:0]  o_dest [6];
    logic [7:0]  o_user [6];
    logic        o_last [6];
    logic        o_valid [6];
    logic        o_ready [6];
    logic [15:0] dropped;

    logic [31:0] n_in_data;
    logic [7:0]  n_in_dest, n_in_user;
    logic        n_in_last, n_in_valid, n_in_ready;
    logic [15:0] n_data [6];
    logic [7:0]  n_dest [6];
    logic [7:0]  n_user [6];
    logic        n_last [6];
    logic        n_valid [6];
    logic        n_ready [6];
    logic [15:0] n_dropped;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    axi_stream_splitter_6 dut (
        .clock(clock), .reset(reset),
        .stream_in_data(in_data), .stream_in_dest(in_dest), .stream_in_user(in_user),
        .stream_in_last(in_last), .stream_in_valid(in_valid), .stream_in_ready(in_ready),
        .stream_out_1_data(o_data[0]), .stream_out_1_dest(o_dest[0]), .stream_out_1_user(o_user[0]),
        .stream_out_1_last(o_last[0]), .stream_out_1_valid(o_valid[0]), .stream_out_1_ready(o_ready[0]),
        .stream_out_2_data(o_data[1]), .stream_out_2_dest(o_dest[1]), .stream_out_2_user(o_user[1]),
        .stream_out_2_last(o_last[1]), .stream_out_2_valid(o_valid[1]), .stream_out_2_ready(o_ready[1]),
        .stream_out_3_data(o_data[2]), .stream_out_3_dest(o_dest[2]), .stream_out_3_user(o_user[2]),
        .stream_out_3_last(o_last[2]), .stream_out_3_valid(o_valid[2]), .stream_out_3_ready(o_ready[2]),
        .stream_out_4_data(o_data[3]), .stream_out_4_dest(o_dest[3]), .stream_out_4_user(o_user[3]),
        .stream_out_4_last(o_last[3]), .stream_out_4_valid(o_valid[3]), .stream_out_4_ready(o_ready[3]),
        .stream_out_5_data(o_data[4]), .stream_out_5_dest(o_dest[4]), .stream_out_5_user(o_user[4]),
        .stream_out_5_last(o_last[4]), .stream_out_5_valid(o_valid[4]), .stream_out_5_ready(o_ready[4]),
        .stream_out_6_data(o_data[5]), .stream_out_6_dest(o_dest[5]), .stream_out_6_user(o_user[5]),
        .stream_out_6_last(o_last[5]), .stream_out_6_valid(o_valid[5]), .stream_out_6_ready(o_ready[5]),
        .dropped_count(dropped)
    );

    axi_stream_splitter_6 #(.MSB_DEST_SUPPORT("FALSE")) dut_n (
        .clock(clock), .reset(reset),
        .stream_in_data(n_in_data), .stream_in_dest(n_in_dest), .stream_in_user(n_in_user),
        .stream_in_last(n_in_last), .stream_in_valid(n_in_valid), .stream_in_ready(n_in_ready),
        .stream_out_1_data(n_data[0]), .stream_out_1_dest(n_dest[0]), .stream_out_1_user(n_user[0]),
        .stream_out_1_last(n_last[0]), .stream_out_1_valid(n_valid[0]), .stream_out_1_ready(n_ready[0]),
        .stream_out_2_data(n_data[1]), .stream_out_2_dest(n_dest[1]), .stream_out_2_user(n_user[1]),
        .stream_out_2_last(n_last[1]), .stream_out_2_valid(n_valid[1]), .stream_out_2_ready(n_ready[1]),
        .stream_out_3_data(n_data[2]), .stream_out_3_dest(n_dest[2]), .stream_out_3_user(n_user[2]),
        .stream_out_3_last(n_last[2]), .stream_out_3_valid(n_valid[2]), .stream_out_3_ready(n_ready[2]),
        .stream_out_4_data(n_data[3]), .stream_out_4_dest(n_dest[3]), .stream_out_4_user(n_user[3]),
        .stream_out_4_last(n_last[3]), .stream_out_4_valid(n_valid[3]), .stream_out_4_ready(n_ready[3]),
        .stream_out_5_data(n_data[4]), .stream_out_5_dest(n_dest[4]), .stream_out_5_user(n_user[4]),
        .stream_out_5_last(n_last[4]), .stream_out_5_valid(n_valid[4]), .stream_out_5_ready(n_ready[4]),
        .stream_out_6_data(n_data[5]), .stream_out_6_dest(n_dest[5]), .stream_out_6_user(n_user[5]),
        .stream_out_6_last(n_last[5]), .stream_out_6_valid(n_valid[5]), .stream_out_6_ready(n_ready[5]),
        .dropped_count(n_dropped)
    );

    typedef struct {
        logic        v;
        logic [31:0] data;
        logic [7:0]  user;
        logic        last;
        logic [5:0]  rdy;
        logic        e_rdy;
        logic [5:0]  e_valid;
        logic        chk;
        int          k;
        logic [15:0] e_data;
        logic [7:0]  e_dest;
        logic [7:0]  e_user;
        logic        e_last;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] valid_vec();
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = o_valid[i];
        return r;
    endfunction

    function automatic logic [5:0] n_valid_vec();
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = n_valid[i];
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] data, input logic [7:0] user,
                         input logic last, input logic [5:0] rdy);
        in_valid = v;
        in_data  = data;
        in_user  = user;
        in_last  = last;
        for (int i = 0; i < 6; i++) o_ready[i] = rdy[i];
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        in_dest    = 8'h07;
        drive(1'b1, 32'h0000_0055, 8'h00, 1'b0, 6'h3F);
        n_in_data  = '0;
        n_in_dest  = '0;
        n_in_user  = '0;
        n_in_last  = 1'b0;
        n_in_valid = 1'b0;
        for (int i = 0; i < 6; i++) n_ready[i] = 1'b1;

        //        v  data          user   last rdy    e_rdy e_valid    chk k  e_data    e_dest e_user e_last e_drop
        vt[0]  = '{1, 32'h02FF_8001, 8'h11, 0, 6'h3F, 1, 6'b000100, 1, 2, 16'h8001, 8'h02, 8'h11, 0, 16'd0};
        vt[1]  = '{1, 32'h00AA_A000, 8'h20, 0, 6'h3F, 1, 6'b000001, 1, 0, 16'hA000, 8'h00, 8'h20, 0, 16'd0};
        vt[2]  = '{1, 32'h0155_A001, 8'h21, 0, 6'h3F, 1, 6'b000010, 1, 1, 16'hA001, 8'h01, 8'h21, 0, 16'd0};
        vt[3]  = '{1, 32'h02AA_A002, 8'h22, 0, 6'h3F, 1, 6'b000100, 1, 2, 16'hA002, 8'h02, 8'h22, 0, 16'd0};
        vt[4]  = '{1, 32'h03FF_A003, 8'h23, 1, 6'h3F, 1, 6'b001000, 1, 3, 16'hA003, 8'h03, 8'h23, 1, 16'd0};
        vt[5]  = '{1, 32'h0400_A004, 8'h24, 0, 6'h3F, 1, 6'b010000, 1, 4, 16'hA004, 8'h04, 8'h24, 0, 16'd0};
        vt[6]  = '{1, 32'h0512_A005, 8'h25, 0, 6'h3F, 1, 6'b100000, 1, 5, 16'hA005, 8'h05, 8'h25, 0, 16'd0};
        vt[7]  = '{0, 32'h0000_0000, 8'h00, 0, 6'h3F, 1, 6'b000000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 16'd0};
        vt[8]  = '{1, 32'h2000_0001, 8'h30, 0, 6'h3F, 1, 6'b000000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 16'd1};
        vt[9]  = '{1, 32'h20FF_0002, 8'h31, 1, 6'h3F, 1, 6'b000000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 16'd2};
        vt[10] = '{1, 32'h2034_0003, 8'h32, 0, 6'h3F, 1, 6'b000000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 16'd3};
        vt[11] = '{1, 32'h00C3_B001, 8'h40, 0, 6'h3E, 1, 6'b000001, 1, 0, 16'hB001, 8'h00, 8'h40, 0, 16'd3};
        vt[12] = '{1, 32'h00C3_B002, 8'h41, 1, 6'h3E, 0, 6'b000001, 1, 0, 16'hB001, 8'h00, 8'h40, 0, 16'd3};
        vt[13] = '{1, 32'h01C3_B003, 8'h42, 0, 6'h3E, 1, 6'b000011, 1, 1, 16'hB003, 8'h01, 8'h42, 0, 16'd3};
        vt[14] = '{0, 32'h0000_0000, 8'h00, 0, 6'h3E, 0, 6'b000001, 1, 0, 16'hB001, 8'h00, 8'h40, 0, 16'd3};
        vt[15] = '{1, 32'h00C3_B002, 8'h41, 1, 6'h3F, 1, 6'b000001, 1, 0, 16'hB002, 8'h00, 8'h41, 1, 16'd3};
        vt[16] = '{0, 32'h0000_0000, 8'h00, 0, 6'h3F, 1, 6'b000000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 16'd3};

        // Reset held with a valid beat offered: nothing may be accepted or shown.
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        next_cycle();
        next_cycle();
        check("reset_valid", 32'(valid_vec()), 32'd0);
        check("reset_dropped", 32'(dropped), 32'd0);
        check("reset_data1", 32'(o_data[0]), 32'd0);
        check("reset_n_valid", 32'(n_valid_vec()), 32'd0);

        reset = 1'b1;
        drive(1'b0, 32'h0, 8'h00, 1'b0, 6'h3F);
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].v, vt[i].data, vt[i].user, vt[i].last, vt[i].rdy);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
            next_cycle();
            check($sformatf("v%0d_valid", i), 32'(valid_vec()), 32'(vt[i].e_valid));
            check($sformatf("v%0d_dropped", i), 32'(dropped), 32'(vt[i].e_drop));
            if (vt[i].chk) begin
                check($sformatf("v%0d_data", i), 32'(o_data[vt[i].k]), 32'(vt[i].e_data));
                check($sformatf("v%0d_dest", i), 32'(o_dest[vt[i].k]), 32'(vt[i].e_dest));
                check($sformatf("v%0d_user", i), 32'(o_user[vt[i].k]), 32'(vt[i].e_user));
                check($sformatf("v%0d_last", i), 32'(o_last[vt[i].k]), 32'(vt[i].e_last));
            end
        end

        // Mid-operation reset while output 2 holds an unaccepted beat.
        drive(1'b1, 32'h0100_D001, 8'h50, 1'b0, 6'b111101);
        next_cycle();
        check("hold2_valid", 32'(valid_vec()), 32'b000010);
        drive(1'b0, 32'h0, 8'h00, 1'b0, 6'b111101);
        next_cycle();
        check("hold2_stable", 32'(o_data[1]), 32'hD001);
        reset = 1'b0;
        drive(1'b1, 32'h0100_D002, 8'h51, 1'b0, 6'b111101);
        #1;
        check("midreset_in_ready", 32'(in_ready), 32'd0);
        next_cycle();
        check("midreset_valid", 32'(valid_vec()), 32'd0);
        check("midreset_data2", 32'(o_data[1]), 32'd0);
        check("midreset_dropped", 32'(dropped), 32'd0);
        reset = 1'b1;
        drive(1'b0, 32'h0, 8'h00, 1'b0, 6'h3F);
        #1;
        check("rerelease_in_ready", 32'(in_ready), 32'd1);
        next_cycle();
        check("rerelease_valid_c1", 32'(valid_vec()), 32'd0);
        next_cycle();
        check("rerelease_valid_c2", 32'(valid_vec()), 32'd0);
        drive(1'b1, 32'h0477_E004, 8'h60, 1'b1, 6'h3F);
        next_cycle();
        check("post_reset_valid", 32'(valid_vec()), 32'b010000);
        check("post_reset_data", 32'(o_data[4]), 32'hE004);
        drive(1'b0, 32'h0, 8'h00, 1'b0, 6'h3F);

        // Sideband-dest instance: data MSBs must not affect routing.
        n_in_valid = 1'b1;
        n_in_dest  = 8'd5;
        n_in_data  = 32'h0000_1234;
        n_in_user  = 8'h77;
        #1;
        check("n_in_ready", 32'(n_in_ready), 32'd1);
        next_cycle();
        check("n_valid_d5", 32'(n_valid_vec()), 32'b100000);
        check("n_data_d5", 32'(n_data[5]), 32'h1234);
        check("n_dest_d5", 32'(n_dest[5]), 32'd5);
        check("n_user_d5", 32'(n_user[5]), 32'h77);
        n_in_dest = 8'd0;
        n_in_data = 32'h05FF_4321;
        next_cycle();
        check("n_valid_d0", 32'(n_valid_vec()), 32'b000001);
        check("n_data_d0", 32'(n_data[0]), 32'h4321);
        check("n_dest_d0", 32'(n_dest[0]), 32'd0);
        n_in_valid = 1'b0;
        next_cycle();
        check("n_idle", 32'(n_valid_vec()), 32'd0);
        check("n_dropped", 32'(n_dropped), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_stream_splitter_6.md
AXI_STREAM_SPLITTER_6 -- requirements
Module: axi_stream_splitter_6

Interface
REQ-001 Parameter INPUT_DATA_WIDTH, default 32, width of the combined input data.
REQ-002 Parameter OUTPUT_DATA_WIDTH, default 16, width of the payload delivered on each output.
REQ-003 Parameter MSB_DEST_SUPPORT, default "TRUE"; when "TRUE", the routing dest is taken from input data[INPUT_DATA_WIDTH-1 -: 8], otherwise from stream_in.dest.
REQ-004 Parameters DEST_1..DEST_6, defaults 0..5, 8-bit dest values routed to stream_out_1..stream_out_6.
REQ-005 clock  input  1  clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 stream_in  axi_stream.slave  INPUT_DATA_WIDTH  combined stream (data, dest, user, tlast, valid, ready).
REQ-008 stream_out_1..stream_out_6  axi_stream.master  OUTPUT_DATA_WIDTH  split streams.
REQ-009 dropped_count  output  16  count of beats whose dest matched no DEST_k.

Function
REQ-010 Routing dest (rdest) SHALL be extracted per REQ-003 each cycle from the current stream_in beat.
REQ-011 Target k SHALL be the lowest index with DEST_k == rdest; if no index matches, the beat is unmatched.
REQ-012 Each output SHALL have a one-entry holding register: out_valid_k, data, dest, user, tlast.
REQ-013 stream_in.ready SHALL be combinational: (~out_valid_k | stream_out_k.ready) for target k; 1 for unmatched beats; 0 in reset.
REQ-014 A transfer occurs when stream_in.valid & stream_in.ready.
REQ-015 On a transfer to k, the register SHALL load data = in.data[OUTPUT_DATA_WIDTH-1:0], dest = rdest, user = in.user[7:0], tlast = in.tlast, and set out_valid_k = 1 on the next edge (latency 1 cycle).
REQ-016 out_valid_k SHALL clear on an edge where stream_out_k.ready & out_valid_k and no new transfer targets k.
REQ-017 Simultaneous drain and load on the same output SHALL leave out_valid_k = 1 with the new beat; no bubble, no loss.
REQ-018 Output registers SHALL hold data, dest, user and tlast stable while out_valid_k & ~stream_out_k.ready.
REQ-019 An unmatched transfer SHALL be consumed and discarded; dropped_count increments by 1 and saturates at 16'hFFFF.
REQ-020 A blocked target (out_valid_k & ~ready_k) SHALL stall the input only; other outputs SHALL continue to drain.
REQ-021 The in.data bits between OUTPUT_DATA_WIDTH and the dest field (sign extension) SHALL be ignored.
REQ-022 tlast SHALL pass through unmodified with its beat; the block generates no tlast of its own.
REQ-023 Beat order per output SHALL equal arrival order; every matched beat SHALL appear exactly once.

Reset
REQ-024 While reset is 0: all out_valid_k = 0, holding registers = 0, dropped_count = 0, stream_in.ready = 0.
REQ-025 A reset asserted mid-operation SHALL discard all held beats at the next edge; no output valid on the first cycle after release.
REQ-026 After reset release with outputs empty, stream_in.ready SHALL be 1 from the first cycle.

Verification
REQ-027 MSB mode: input data 32'h02FF_8001, all outputs ready -> next cycle stream_out_3 valid with data 16'h8001 and dest 2; other outputs stay invalid.
REQ-028 Backpressure: stream_out_1.ready = 0 and two beats for dest 0 -> first beat held stable; stream_in.ready = 0 for the second beat until ready rises; both beats delivered in order.
REQ-029 Unmatched: three beats with dest 8'h20 -> consumed with ready = 1, no output valid, dropped_count = 3.
REQ-030 Interleave: dests 0,1,2,3,4,5 on consecutive cycles, all ready -> each output pulses valid once, one cycle after its input beat; tlast is forwarded only on the beat that carried it.
REQ-031 Non-MSB mode: stream_in.dest = 5, data 32'h0000_1234 -> stream_out_6 data 16'h1234.
REQ-032 Reset while stream_out_2 holds an unaccepted beat -> valid drops; no output appears after release until a new transfer.
